tia_write_sequencer: RTL and testbench

- Replays a queued stream of timed TIA register writes onto the chip's CPU-side bus (a, d, rw, phi2), as a software-free 6507 stand-in for kernel playback.
- Runs on the color clock and derives its own CPU cycle, one CPU cycle per 3 clk.
- Honours rdy, so a WSYNC write stalls playback exactly as the CPU would be halted.
- Sits between a host-side kernel loader and tia_no_audio.

---
 rtl/tia_write_sequencer_if.sv | 25 ++
 rtl/tia_write_sequencer.sv | 138 +++++++++++++
 tb/tb_tia_write_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tia_write_sequencer_if.sv
// Host/TIA-side bus of tia_write_sequencer: write-queue push port plus the 6507-style bus.
interface tia_write_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_delay;
  logic [5:0] in_addr;
  logic [7:0] in_data;
  logic       rdy;
  logic [5:0] a;
  logic [7:0] d;
  logic       rw;
  logic       phi2;
  logic       busy;
  logic       wr_done;

  modport master (
    output in_valid, in_delay, in_addr, in_data, rdy,
    input  in_ready, a, d, rw, phi2, busy, wr_done
  );

  modport slave (
    input  in_valid, in_delay, in_addr, in_data, rdy,
    output in_ready, a, d, rw, phi2, busy, wr_done
  );
endinterface

// File: rtl/tia_write_sequencer.sv
// Replays queued, timed TIA register writes as a 6507 bus stand-in (one CPU cycle = 3 clk).
// Optional saturating write/stall counters: define TIA_WRITE_SEQUENCER_STATS_EN.
module tia_write_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tia_write_sequencer_if.slave bus
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  ,
  output logic [15:0]          writes_issued,
  output logic [15:0]          stall_cycles
`endif
);
  typedef struct packed {
    logic [7:0] delay;
    logic [5:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t        state;
  logic [1:0]    phase, phase_nxt;
  logic          boundary;
  logic [7:0]    cnt;
  logic [5:0]    addr_q, a_q;
  logic [7:0]    data_q, d_q;
  logic          rw_q, phi2_q, wr_done_q;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  entry_t        head;

  assign phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
  assign boundary  = (phase == 2'd2);
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.in_valid && !full;
  // WRITE ends at the boundary, so it pops like IDLE; occupancy is pre-push.
  assign pop       = boundary && (state != S_WAIT) && !empty;
  assign head      = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.in_delay, bus.in_addr, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      a_q       <= '0;
      d_q       <= '0;
      rw_q      <= 1'b1;
      phi2_q    <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      phi2_q    <= (phase_nxt != 2'd0);
      wr_done_q <= (state == S_WRITE) && (phase_nxt == 2'd2);
      if (boundary) begin
        case (state)
          S_WAIT: begin
            if (bus.rdy) begin
              if (cnt == 8'd1) begin
                state <= S_WRITE;
                a_q   <= addr_q;
                d_q   <= data_q;
                rw_q  <= 1'b0;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          default: begin
            if (empty) begin
              state <= S_IDLE;
              rw_q  <= 1'b1;
            end else if (head.delay == 8'd0 && bus.rdy) begin
              state <= S_WRITE;
              a_q   <= head.addr;
              d_q   <= head.data;
              rw_q  <= 1'b0;
            end else begin
              // A stalled zero-delay write parks as a one-cycle wait: it fires
              // at the first boundary that sees rdy high.
              state  <= S_WAIT;
              cnt    <= (head.delay == 8'd0) ? 8'd1 : head.delay;
              addr_q <= head.addr;
              data_q <= head.data;
              rw_q   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready = !full;
  assign bus.busy     = !empty || (state != S_IDLE);
  assign bus.a        = a_q;
  assign bus.d        = d_q;
  assign bus.rw       = rw_q;
  assign bus.phi2     = phi2_q;
  assign bus.wr_done  = wr_done_q;

`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      writes_issued <= '0;
      stall_cycles  <= '0;
    end else begin
      if (wr_done_q && writes_issued != 16'hFFFF)
        writes_issued <= writes_issued + 16'd1;
      if (boundary && !bus.rdy && state != S_IDLE && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tia_write_sequencer.sv
// Directed + randomized bench for tia_write_sequencer; expected write timing comes from
// the pop/delay arithmetic (write at boundary + 3*delay) over a logged bus history.
module tb_tia_write_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  tia_write_sequencer_if bus ();

`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  logic [15:0] writes_issued, stall_cycles;
  tia_write_sequencer dut (.clk(clk), .reset(reset), .bus(bus),
                           .writes_issued(writes_issued), .stall_cycles(stall_cycles));
`else
  tia_write_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
    logic       rw;
    logic       phi2;
    logic       wr_done;
    logic       busy;
  } snap_t;

  typedef struct {
    int         e;
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  snap_t hist [int];
  wr_t   wq [$];
  int    n_done = 0;
  int    n_asrt = 0;
  int    n_fail = 0;
  int    rst_e  = 0;

  // Bus monitor: a write cycle starts on any clk with rw low and phi2 low.
  always @(posedge clk) begin
    #1;
    hist[cyc] = '{a: bus.a, d: bus.d, rw: bus.rw, phi2: bus.phi2,
                  wr_done: bus.wr_done, busy: bus.busy};
    if (!reset && bus.rw === 1'b0 && bus.phi2 === 1'b0)
      wq.push_back('{e: cyc, a: bus.a, d: bus.d});
    if (bus.wr_done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // First CPU-cycle boundary strictly after edge pe (phase is 0 right after reset).
  function automatic int nb(input int pe);
    int e;
    e = pe + 1;
    while ((e - rst_e) % 3 != 0) e++;
    return e;
  endfunction

  task automatic push(input logic [7:0] dl, input logic [5:0] ad, input logic [7:0] dt,
                      output int pe);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_delay = dl;
    bus.in_addr  = ad;
    bus.in_data  = dt;
    @(posedge clk);
    #2;
    pe = cyc;
  endtask

  task automatic drop();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, wq.size(), n);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) tick();
  endtask

  initial begin
    int pe, pe2, s, wb, nd, t, idx, occ, nref;
    logic rdy_b;
    logic [7:0] rd [12];
    logic [5:0] ra [30];
    logic [7:0] rv [30];
    logic [15:0] st0;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_delay = '0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.rdy      = 1'b1;
    st0 = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_e = cyc;
    chk("rst_a", hist[cyc].a, 0);
    chk("rst_d", hist[cyc].d, 0);
    chk("rst_rw", hist[cyc].rw, 1);
    chk("rst_phi2", hist[cyc].phi2, 0);
    chk("rst_wr_done", hist[cyc].wr_done, 0);
    chk("rst_busy", hist[cyc].busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    chk("phase1_phi2", hist[rst_e+1].phi2, 1);
    chk("phase2_phi2", hist[rst_e+2].phi2, 1);
    chk("phase0_phi2", hist[rst_e+3].phi2, 0);

    // single delay-0 write
    wb = wq.size();
    push(8'd0, 6'h09, 8'h1E, pe);
    drop();
    s = nb(pe);
    wait_writes("t1_timeout", wb + 1, 30);
    wait_edge(s + 4);
    if (wq.size() > wb) begin
      chk("t1_start", wq[wb].e, s);
      chk("t1_a", wq[wb].a, 6'h09);
      chk("t1_d", wq[wb].d, 8'h1E);
    end
    chk("t1_phi2_0", hist[s].phi2, 0);
    chk("t1_phi2_1", hist[s+1].phi2, 1);
    chk("t1_phi2_2", hist[s+2].phi2, 1);
    chk("t1_rw_low", {hist[s].rw, hist[s+1].rw, hist[s+2].rw, hist[s+3].rw}, 4'b0001);
    chk("t1_wr_done", {hist[s+1].wr_done, hist[s+2].wr_done, hist[s+3].wr_done}, 3'b010);
    chk("t1_busy_during", hist[s+1].busy, 1);
    chk("t1_busy_after", hist[s+3].busy, 0);
    chk("t1_done_cnt", n_done, 1);

    // three back-to-back delay-0 writes
    wb = wq.size();
    push(8'd0, 6'h0D, 8'hA1, pe);
    push(8'd0, 6'h0E, 8'hA2, pe2);
    push(8'd0, 6'h0F, 8'hA3, pe2);
    drop();
    s = nb(pe);
    wait_writes("t2_timeout", wb + 3, 40);
    wait_edge(s + 10);
    for (int i = 0; i < 3; i++) begin
      if (wq.size() > wb + i) begin
        chk("t2_start", wq[wb+i].e, s + 3*i);
        chk("t2_a", wq[wb+i].a, 6'h0D + i);
        chk("t2_d", wq[wb+i].d, 8'hA1 + i);
      end
    end
    nd = 0;
    for (int k = s; k < s + 9; k++) if (hist[k].rw === 1'b0) nd++;
    chk("t2_rw_low_9", nd, 9);
    chk("t2_rw_high_after", hist[s+9].rw, 1);

    // delay 5: write starts 15 clk after the pop boundary
    wb = wq.size();
    push(8'd5, 6'h06, 8'h5A, pe);
    drop();
    s = nb(pe);
    wait_writes("t3_timeout", wb + 1, 60);
    if (wq.size() > wb) begin
      chk("t3_start", wq[wb].e, s + 15);
      chk("t3_a", wq[wb].a, 6'h06);
      chk("t3_d", wq[wb].d, 8'h5A);
    end
    nd = 0;
    for (int k = s; k < s + 15; k++) if (hist[k].rw === 1'b1) nd++;
    chk("t3_rw_high_15", nd, 15);
    wait_edge(s + 20);

    // WSYNC write, then rdy low for 20 CPU cycles starting mid-cycle
    wb = wq.size();
    nd = n_done;
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
    st0 = stall_cycles;
`endif
    push(8'd0, 6'h02, 8'h00, pe);
    push(8'd0, 6'h09, 8'h44, pe2);
    drop();
    s = nb(pe);
    wait_edge(s);
    @(negedge clk);
    bus.rdy = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    bus.rdy = 1'b1;
    wait_writes("t4_timeout", wb + 2, 40);
    wait_edge(s + 67);
    if (wq.size() > wb + 1) begin
      chk("t4_wsync_start", wq[wb].e, s);
      chk("t4_wsync_a", wq[wb].a, 6'h02);
      chk("t4_second_start", wq[wb+1].e, s + 63);
      chk("t4_second_a", wq[wb+1].a, 6'h09);
      chk("t4_second_d", wq[wb+1].d, 8'h44);
    end
    chk("t4_wsync_done", hist[s+2].wr_done, 1);
    chk("t4_done_cnt", n_done - nd, 2);
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
    chk("t4_stall_cycles", stall_cycles - st0, 20);
`endif
    chk("t4_rw_stalled", hist[s+30].rw, 1);

    // fill to full with in_valid held high
    wb = wq.size();
    for (int i = 0; i < 30; i++) begin
      ra[i] = 6'($urandom_range(0, 63));
      rv[i] = 8'($urandom_range(0, 255));
    end
    idx = 0;
    nref = 0;
    t = 0;
    while (idx < 30 && t < 400) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_delay = 8'd0;
      bus.in_addr  = ra[idx];
      bus.in_data  = rv[idx];
      occ = idx - (wq.size() - wb);
      chk("t5_in_ready", bus.in_ready, (occ < 16) ? 1 : 0);
      rdy_b = bus.in_ready;
      if (!rdy_b) nref++;
      @(posedge clk);
      if (rdy_b) idx++;
      t++;
    end
    drop();
    chk("t5_refused_seen", (nref != 0) ? 1 : 0, 1);
    wait_writes("t5_timeout", wb + 30, 200);
    repeat (10) tick();
    chk("t5_count", wq.size() - wb, 30);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (wq.size() > wb + i) begin
        if (wq[wb+i].a !== ra[i] || wq[wb+i].d !== rv[i]) nd++;
        if (i > 0 && wq[wb+i].e != wq[wb+i-1].e + 3) nd++;
      end
    end
    chk("t5_order_spacing", nd, 0);

    // random delays, rdy high: write_i = pop_i + 3*delay_i, pop_i = end of write_{i-1}
    wb = wq.size();
    for (int i = 0; i < 12; i++) begin
      rd[i] = 8'($urandom_range(0, 4));
      ra[i] = 6'($urandom_range(0, 63));
      rv[i] = 8'($urandom_range(0, 255));
    end
    push(rd[0], ra[0], rv[0], pe);
    for (int i = 1; i < 12; i++) push(rd[i], ra[i], rv[i], pe2);
    drop();
    wait_writes("rnd_timeout", wb + 12, 400);
    t = nb(pe) + 3 * int'(rd[0]);
    for (int i = 0; i < 12; i++) begin
      if (wq.size() > wb + i) begin
        chk("rnd_start", wq[wb+i].e, t);
        chk("rnd_a", wq[wb+i].a, ra[i]);
        chk("rnd_d", wq[wb+i].d, rv[i]);
      end
      if (i < 11) t = t + 3 + 3 * int'(rd[i+1]);
    end
    repeat (6) tick();
    chk("rnd_done_total", n_done, wq.size());

    // reset during WAIT (cnt = 3) with 4 more entries queued
    wb = wq.size();
    nd = n_done;
    push(8'd5, 6'h11, 8'h01, pe);
    for (int i = 0; i < 4; i++) push(8'd0, 6'h12, 8'h02, pe2);
    drop();
    s = nb(pe);
    wait_edge(s + 6);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    rst_e = cyc;
    chk("t6_rw", hist[cyc].rw, 1);
    chk("t6_busy", hist[cyc].busy, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_phi2", hist[cyc].phi2, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) tick();
    chk("t6_no_writes", wq.size() - wb, 0);
    chk("t6_no_done", n_done - nd, 0);
    chk("t6_busy_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
